ifetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer that drives the synchronous-read instruction memory.
//  - Owns the program counter and issues word reads to imem.
//  - Buffers returned instructions, tagged with their PC, in a small FIFO.
//  - Presents them to decode over a valid/ready handshake.
//  - Handles branch/jump redirects: flush, then restart fetch at the target.
//  - Sits between imem and the decode stage; the only master of the imem address port.

---
 rtl/ifetch_ctrl.sv | 132 +++++++++++++
 tb/tb_ifetch_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// ifetch_ctrl : PC sequencer driving sync-read imem, PC-tagged FIFO to decode
// Rev 1.0
// ============================================================================
module ifetch_ctrl #(
  parameter int             N        = 32,
  parameter int             AW       = 5,
  parameter int             DEPTH    = 2,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run_en,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [N-1:0]  imem_rdata,
  output logic [N-1:0]  instr,
  output logic [N-1:0]  instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          redirect,
  input  logic [N-1:0]  redirect_pc,
  output logic          busy
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   C_DEPTH = (CW+1)'(DEPTH);
  localparam logic [PW-1:0] C_LAST  = PW'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  pc;
  logic [N-1:0]  tag;
  logic          inflight;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [N-1:0]  fifo_instr [DEPTH];
  logic [N-1:0]  fifo_pc    [DEPTH];

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;
  logic [N-1:0]  target;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == C_LAST) ? '0 : p + PW'(1);
  endfunction

  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;
  // A return is dropped when a redirect lands in its arrival cycle.
  assign push        = inflight & ~redirect;
  // Counting the in-flight read as occupied keeps the FIFO from overflowing.
  assign occupancy   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign target      = redirect_pc & ~N'(3);
  assign imem_req    = issue;
  assign imem_addr   = pc[AW+1:2];
  assign busy        = (state == RUN) | inflight;
  assign instr       = instr_valid ? fifo_instr[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (run_en) state_nxt = RUN;
      end
      RUN: begin
        if (!run_en) state_nxt = IDLE;
        issue = !redirect && (occupancy < C_DEPTH);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (redirect) begin
        pc <= target;
      end else if (issue) begin
        pc  <= pc + N'(4);
        tag <= pc;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ifetch_ctrl : directed bench with PC scoreboard for ifetch_ctrl
// Rev 1.0
// ============================================================================
module tb_ifetch_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        run_en;
  logic        imem_req;
  logic [4:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] imem [32];

  ifetch_ctrl #(.N(32), .AW(5), .DEPTH(2), .RESET_PC(32'h0)) dut (
    .clock       (clock),
    .reset       (reset),
    .run_en      (run_en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  initial for (int k = 0; k < 32; k++) imem[k] = k;

  always @(posedge clock) if (imem_req) imem_rdata <= imem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every accepted instruction must be the next expected PC.
  always @(negedge clock) begin
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop_pc", instr_pc, 32'hDEAD_BEEF);
      end else begin
        logic [31:0] p;
        p = exp_q.pop_front();
        chk("sb_pc", instr_pc, p);
        chk("sb_instr", instr, {27'b0, p[6:2]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; run_en = 1'b0; instr_ready = 1'b1;
    redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req",   32'(imem_req),    0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr,            0);
    chk("rst_pc",    instr_pc,         0);
    chk("rst_busy",  32'(busy),        0);
    chk("rst_addr",  32'(imem_addr),   0);

    // Start streaming from RESET_PC
    cyc(); reset = 1'b0; run_en = 1'b1; push_stream(0, 40);
    @(negedge clock); chk("c0_req", 32'(imem_req), 0);
    cyc(); @(negedge clock);
    chk("c1_req", 32'(imem_req), 1);
    chk("c1_addr", 32'(imem_addr), 0);
    cyc(); @(negedge clock);
    chk("c2_valid", 32'(instr_valid), 0);
    chk("c2_busy", 32'(busy), 1);
    for (int i = 0; i < 10; i++) begin
      cyc(); @(negedge clock);
      chk("stream_valid", 32'(instr_valid), 1);
    end

    // Stall: head held, no new reads once FIFO + in-flight fill it
    cyc(); instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_valid", 32'(instr_valid), 1);
      chk("stall_pc", instr_pc, exp_q[0]);
      chk("stall_instr", instr, {27'b0, exp_q[0][6:2]});
      chk("stall_req", 32'(imem_req), 0);
      cyc();
    end
    instr_ready = 1'b1;
    repeat (4) cyc();

    // Redirect mid-stream with a read in flight
    redirect = 1'b1; redirect_pc = 32'h13;
    @(negedge clock); chk("rd1_req", 32'(imem_req), 0);
    cyc(); redirect = 1'b0; exp_q.delete(); push_stream(32'h10, 20);
    @(negedge clock);
    chk("rd1_valid_t1", 32'(instr_valid), 0);
    chk("rd1_req_t1", 32'(imem_req), 1);
    chk("rd1_addr_t1", 32'(imem_addr), 4);
    cyc(); @(negedge clock); chk("rd1_valid_t2", 32'(instr_valid), 0);
    cyc(); @(negedge clock);
    chk("rd1_valid_t3", 32'(instr_valid), 1);
    chk("rd1_pc_t3", instr_pc, 32'h10);
    repeat (3) cyc();

    // Redirect with FIFO full (stalled), target near the imem wrap point
    instr_ready = 1'b0;
    repeat (2) cyc();
    redirect = 1'b1; redirect_pc = 32'h74;
    @(negedge clock);
    chk("rd2_full_valid", 32'(instr_valid), 1);
    chk("rd2_req", 32'(imem_req), 0);
    cyc(); redirect = 1'b0; instr_ready = 1'b1; exp_q.delete(); push_stream(32'h74, 12);
    @(negedge clock);
    chk("rd2_valid_t1", 32'(instr_valid), 0);
    chk("wrap_addr29", 32'(imem_addr), 29);
    cyc(); @(negedge clock); chk("wrap_addr30", 32'(imem_addr), 30);
    cyc(); @(negedge clock); chk("wrap_addr31", 32'(imem_addr), 31);
    cyc(); @(negedge clock);
    chk("wrap_addr0", 32'(imem_addr), 0);
    chk("wrap_req", 32'(imem_req), 1);
    repeat (3) cyc();

    // run_en drop: exactly one read (0x40) issues and is delivered
    redirect = 1'b1; redirect_pc = 32'h40;
    cyc(); redirect = 1'b0; run_en = 1'b0; exp_q.delete(); push_stream(32'h40, 1);
    @(negedge clock);
    chk("stop_req_t1", 32'(imem_req), 1);
    chk("stop_busy_t1", 32'(busy), 1);
    cyc(); @(negedge clock);
    chk("stop_req_t2", 32'(imem_req), 0);
    chk("stop_busy_t2", 32'(busy), 1);
    cyc(); @(negedge clock);
    chk("stop_busy_t3", 32'(busy), 0);
    chk("stop_valid_t3", 32'(instr_valid), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge clock);
      chk("stop_req_idle", 32'(imem_req), 0);
      chk("stop_valid_idle", 32'(instr_valid), 0);
    end
    chk("stop_q_empty", 32'(exp_q.size()), 0);

    // Reset between a read's issue and its return
    cyc(); run_en = 1'b1; push_stream(32'h44, 4);
    @(negedge clock); chk("rs_req_idle", 32'(imem_req), 0);
    cyc(); @(negedge clock);
    chk("rs_req", 32'(imem_req), 1);
    chk("rs_addr", 32'(imem_addr), 17);
    cyc(); reset = 1'b1; run_en = 1'b0; exp_q.delete();
    #1;
    chk("rs_async_req",   32'(imem_req),    0);
    chk("rs_async_valid", 32'(instr_valid), 0);
    chk("rs_async_busy",  32'(busy),        0);
    chk("rs_async_instr", instr,            0);
    chk("rs_async_pc",    instr_pc,         0);
    cyc(); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rs_no_stale", 32'(instr_valid), 0);
      chk("rs_no_req", 32'(imem_req), 0);
      cyc();
    end

    // Restart after reset fetches from RESET_PC again
    run_en = 1'b1; push_stream(0, 16);
    repeat (3) cyc();
    @(negedge clock); chk("rs_restart_valid", 32'(instr_valid), 1);
    repeat (5) cyc();
    @(negedge clock); chk("rs_restart_count", 32'(exp_q.size()), 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
